// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for the decode stage.
// Decodes the immediate, format code and illegal flag of a 32-bit
// instruction. The result is registered behind a valid/ready handshake.
// A skid register holds one extra result, so in_ready can be driven from a
// flop without losing throughput.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   // Only RV32 and RV64 immediate widths make sense.
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_Z    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_FENCE   = 7'b0001111;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   // One decoded result, as held in the output and skid registers.
   typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_e             fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

   entry_t     dec;
   logic [31:0] imm32;

   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;

   logic   accept;
   logic   out_free;

   // Decode the incoming instruction. The result is a 32-bit immediate, which is sign-extended to XLEN.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      imm32       = '0;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b0;
      dec.tag     = in_tag;
      unique case (in_inst[6:0])
         OP_LOAD, OP_FENCE, OP_OPIMM, OP_JALR: begin
            imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            dec.fmt = FMT_I;
         end
         OP_SYSTEM: begin
            if (in_inst[14]) begin
               imm32   = {27'b0, in_inst[19:15]};
               dec.fmt = FMT_Z;
            end else begin
               imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
               dec.fmt = FMT_I;
            end
         end
         OP_OPIMM32: begin
            if (XLEN == 64) begin
               imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
               dec.fmt = FMT_I;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {in_inst[31:12], 12'b0};
            dec.fmt = FMT_U;
         end
         OP_STORE: begin
            imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            dec.fmt = FMT_S;
         end
         OP_BRANCH: begin
            imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            dec.fmt = FMT_B;
         end
         OP_JAL: begin
            imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            dec.fmt = FMT_J;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Bit 31 of the zimm value is always 0, so sign extension also covers zero extension.
      dec.imm = XLEN'($signed(imm32));
   end

   // A flush discards the input presented in the same cycle.
   assign accept   = in_valid & in_ready_q & ~flush;
   assign out_free = ~out_valid_q | out_ready;

   // Handshake control: route each result to the output or skid register, keeping FIFO order.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            // in_ready is low while skid is full, so no new accept can collide here.
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         // NOTE: the data registers are reset as well, so the outputs never carry X before the first result.
         out_q        <= ENTRY_RST;
         skid_q       <= ENTRY_RST;
      end else begin
         // NOTE: use non-blocking assignments, so every flop samples values from before the edge.
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         out_q        <= out_d;
         skid_q       <= skid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe. It drives an XLEN=32 instance and an
// XLEN=64 instance with the same stimulus.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_imm32, out_tag32;
   logic [2:0]  out_fmt32;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [31:0] out_tag64;
   logic [2:0]  out_fmt64;

   int n_vec  = 0;
   int n_miss = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Apply one instruction with out_ready high and check the result on both widths one cycle later.
   task automatic vec(input string name, input logic [31:0] inst, input logic [31:0] tag,
                      input logic [31:0] e32, input logic [63:0] e64,
                      input logic [2:0] f32, input logic [2:0] f64,
                      input logic i32, input logic i64);
      in_valid  = 1'b1;
      in_inst   = inst;
      in_tag    = tag;
      out_ready = 1'b1;
      step();
      check({name, " valid32"}, 64'(out_valid32), 64'd1);
      check({name, " imm32"},   64'(out_imm32),   64'(e32));
      check({name, " fmt32"},   64'(out_fmt32),   64'(f32));
      check({name, " ill32"},   64'(out_illegal32), 64'(i32));
      check({name, " tag32"},   64'(out_tag32),   64'(tag));
      check({name, " valid64"}, 64'(out_valid64), 64'd1);
      check({name, " imm64"},   out_imm64,        e64);
      check({name, " fmt64"},   64'(out_fmt64),   64'(f64));
      check({name, " ill64"},   64'(out_illegal64), 64'(i64));
   endtask

   function automatic logic [31:0] bp_imm(input int i);
      logic [11:0] v;
      v = 12'(i * 37 - 100);
      return {{20{v[11]}}, v};
   endfunction

   function automatic logic [31:0] bp_inst(input int i);
      logic [11:0] v;
      v = 12'(i * 37 - 100);
      return {v, 5'd0, 3'b000, 5'd1, 7'b0010011};
   endfunction

   initial begin
      logic [31:0] ready_pat;
      int          sent, rcv, cyc;
      logic        stall_prev, skid_model, in_hs, out_hs, saw_bp;
      logic [31:0] imm_prev, tag_prev;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      step();

      // Reset state
      check("rst out_valid", 64'(out_valid32), 64'd0);
      check("rst in_ready",  64'(in_ready32),  64'd1);
      check("rst out_imm",   64'(out_imm32),   64'd0);
      check("rst out_fmt",   64'(out_fmt32),   64'd7);
      check("rst out_ill",   64'(out_illegal32), 64'd0);
      check("rst out_tag",   64'(out_tag32),   64'd0);
      check("rst out_imm64", out_imm64,        64'd0);
      rst = 1'b0;

      // Decode vectors. The first one is accepted on the first edge after reset release.
      vec("addi-1",    32'hFFF00093, 32'h100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd0, 1'b0, 1'b0);
      vec("beq-4",     32'hFE000EE3, 32'h101, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
      vec("lui",       32'h80000037, 32'h102, 32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 3'd3, 1'b0, 1'b0);
      vec("csrrwi",    32'h3002D073, 32'h103, 32'h00000005, 64'h5,                3'd5, 3'd5, 1'b0, 1'b0);
      vec("opc7f",     32'h0000007F, 32'h104, 32'h0,        64'h0,                3'd7, 3'd7, 1'b1, 1'b1);
      vec("opimm32",   32'h0000001B, 32'h105, 32'h0,        64'h0,                3'd7, 3'd0, 1'b1, 1'b0);
      vec("addiw-1",   32'hFFF0009B, 32'h106, 32'h0,        64'hFFFFFFFFFFFFFFFF, 3'd7, 3'd0, 1'b1, 1'b0);
      vec("sw-4",      32'hFE112E23, 32'h107, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 3'd1, 1'b0, 1'b0);
      vec("jal+2048",  32'h001000EF, 32'h108, 32'h00000800, 64'h800,              3'd4, 3'd4, 1'b0, 1'b0);
      vec("jal-8",     32'hFF9FF06F, 32'h109, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd4, 3'd4, 1'b0, 1'b0);
      vec("lw+7ff",    32'h7FF12083, 32'h10A, 32'h000007FF, 64'h7FF,              3'd0, 3'd0, 1'b0, 1'b0);
      vec("csrrw",     32'h30029073, 32'h10B, 32'h00000300, 64'h300,              3'd0, 3'd0, 1'b0, 1'b0);
      vec("fence",     32'h0FF0000F, 32'h10C, 32'h000000FF, 64'hFF,               3'd0, 3'd0, 1'b0, 1'b0);
      vec("jalr-2048", 32'h800000E7, 32'h10D, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd0, 3'd0, 1'b0, 1'b0);
      vec("auipc",     32'h00001017, 32'h10E, 32'h00001000, 64'h1000,             3'd3, 3'd3, 1'b0, 1'b0);
      vec("beq+8",     32'h00000463, 32'h10F, 32'h00000008, 64'h8,                3'd2, 3'd2, 1'b0, 1'b0);
      vec("zero",      32'h00000000, 32'h110, 32'h0,        64'h0,                3'd7, 3'd7, 1'b1, 1'b1);

      in_valid = 1'b0;
      step();
      check("drain out_valid", 64'(out_valid32), 64'd0);

      // Backpressure: 8 tagged instructions against a fixed ready pattern
      ready_pat  = 32'hB269C5A3;
      sent       = 0;
      rcv        = 0;
      cyc        = 0;
      stall_prev = 1'b0;
      skid_model = 1'b0;
      saw_bp     = 1'b0;
      imm_prev   = '0;
      tag_prev   = '0;
      while (rcv < 8 && cyc < 200) begin
         out_ready = ready_pat[cyc % 32];
         in_valid  = (sent < 8);
         in_inst   = bp_inst(sent);
         in_tag    = 32'(sent);
         if (stall_prev) begin
            check("bp stable valid", 64'(out_valid32), 64'd1);
            check("bp stable tag",   64'(out_tag32),   64'(tag_prev));
            check("bp stable imm",   64'(out_imm32),   64'(imm_prev));
         end
         if (!in_ready32) begin
            saw_bp = 1'b1;
            check("bp in_ready low only with skid full", 64'(skid_model), 64'd1);
         end
         in_hs  = in_valid && in_ready32;
         out_hs = out_valid32 && out_ready;
         if (out_hs) begin
            check("bp tag32", 64'(out_tag32), 64'(rcv));
            check("bp imm32", 64'(out_imm32), 64'(bp_imm(rcv)));
            check("bp tag64", 64'(out_tag64), 64'(rcv));
            check("bp imm64", out_imm64, {{32{bp_imm(rcv)[31]}}, bp_imm(rcv)});
            rcv++;
         end
         if (out_valid32 && !out_ready && in_hs) skid_model = 1'b1;
         else if (out_hs)                        skid_model = 1'b0;
         stall_prev = out_valid32 && !out_ready;
         imm_prev   = out_imm32;
         tag_prev   = out_tag32;
         if (in_hs) sent++;
         step();
         cyc++;
      end
      check("bp all delivered", 64'(rcv), 64'd8);
      check("bp in_ready dropped", 64'(saw_bp), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp no duplicate", 64'(out_valid32), 64'd0);

      // Flush with output and skid both full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00100093;
      in_tag    = 32'hA1;
      step();
      check("fl A loaded", 64'(out_tag32), 64'hA1);
      in_inst = 32'h00200093;
      in_tag  = 32'hB2;
      step();
      check("fl skid full in_ready", 64'(in_ready32), 64'd0);
      check("fl A held", 64'(out_tag32), 64'hA1);
      flush   = 1'b1;
      in_inst = 32'h00300093;
      in_tag  = 32'hC3;
      step();
      flush = 1'b0;
      check("fl out_valid32", 64'(out_valid32), 64'd0);
      check("fl in_ready32",  64'(in_ready32),  64'd1);
      check("fl out_valid64", 64'(out_valid64), 64'd0);
      check("fl in_ready64",  64'(in_ready64),  64'd1);
      in_inst   = 32'h00400093;
      in_tag    = 32'hD4;
      out_ready = 1'b1;
      step();
      check("fl D valid", 64'(out_valid32), 64'd1);
      check("fl D tag",   64'(out_tag32),   64'hD4);
      check("fl D imm",   64'(out_imm32),   64'd4);
      in_valid = 1'b0;
      step();
      check("fl no stale skid", 64'(out_valid32), 64'd0);

      // Input presented in the flush cycle is discarded
      in_valid = 1'b1;
      in_inst  = 32'h00500093;
      in_tag   = 32'hE5;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl drop E now",   64'(out_valid32), 64'd0);
      step();
      check("fl drop E later", 64'(out_valid32), 64'd0);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h0000007F;
      in_tag    = 32'h55;
      step();
      in_inst = 32'h00600093;
      in_tag  = 32'h56;
      step();
      in_valid = 1'b0;
      check("ar pre illegal", 64'(out_illegal32), 64'd1);
      check("ar pre in_ready", 64'(in_ready32), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("ar out_valid", 64'(out_valid32), 64'd0);
      check("ar in_ready",  64'(in_ready32),  64'd1);
      check("ar out_imm",   64'(out_imm32),   64'd0);
      check("ar out_fmt",   64'(out_fmt32),   64'd7);
      check("ar out_ill",   64'(out_illegal32), 64'd0);
      check("ar out_tag",   64'(out_tag32),   64'd0);
      check("ar out_imm64", out_imm64,        64'd0);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'hFFF00093;
      in_tag    = 32'h66;
      out_ready = 1'b1;
      step();
      check("ar first valid", 64'(out_valid32), 64'd1);
      check("ar first tag",   64'(out_tag32),   64'h66);
      check("ar first imm",   64'(out_imm32),   64'hFFFFFFFF);
      in_valid = 1'b0;
      step();
      check("ar skid cleared", 64'(out_valid32), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage.
- Accepts a 32-bit RV instruction plus a sideband tag (typically the PC) over a valid/ready handshake.
- Emits the XLEN-wide immediate, a format code and an illegal-opcode flag one cycle later.
- Adds XLEN=64 support, the CSR zimm format and explicit illegal reporting.
- A two-entry skid buffer keeps full throughput with a registered in_ready; a synchronous flush squashes in-flight entries on redirect.

Parameters:
- XLEN, 32: output immediate width; legal values 32 or 64 only (elaboration error otherwise).
- TAG_W, 32: width of the tag carried alongside the instruction.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous squash of all buffered entries
- in_valid  input  1  instruction valid
- in_ready  output  1  block can accept; registered
- in_inst  input  32  instruction word
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_imm  output  XLEN  sign/zero-extended immediate
- out_fmt  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 7=none
- out_illegal  output  1  opcode not recognised
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Decode on opcode = inst[6:0]. Every immediate except Z is sign-extended from inst[31] to XLEN.
  - I: 1100111, 0000011, 0010011, 0001111, 1110011 with funct3[2]=0, and 0011011 when XLEN=64. imm = inst[31:20].
  - Z: 1110011 with funct3 (inst[14:12]) bit 2 = 1. imm = zero-extended inst[19:15].
  - U: 0110111, 0010111. imm = {inst[31:12], 12'b0}, sign-extended above bit 31.
  - S: 0100011. imm = {inst[31:25], inst[11:7]}.
  - B: 1100011. imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: 1101111. imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode (including 0011011 when XLEN=32): out_imm=0, out_fmt=7, out_illegal=1. No X values on outputs ever.
- Storage: main output register (out_*) and one skid register; each has a valid bit.
- Transfer rules: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when the output register is empty or draining.
- Skid path: if the output register holds unconsumed data (out_valid & !out_ready) when an input is accepted, the decoded result goes to skid.
- in_ready = !skid_valid, registered. At most one stall bubble between skid fill and in_ready deassertion is permitted, but no entry is ever dropped.
- When the output drains and skid is valid, skid moves to the output register the same edge; skid_valid clears.
- Simultaneous accept + drain with skid empty: new result loads directly into the output register; out_valid stays 1.
- Order is strictly FIFO; the tag always travels with its own immediate.
- out_* remain stable while out_valid & !out_ready.
- flush: on the next edge out_valid=0, skid_valid=0, in_ready=1. An input presented in the flush cycle is discarded. flush overrides all other events.
- Reset (async assert, any time including mid-transfer): out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=7, out_illegal=0, out_tag=0.
- After reset deassertion the block accepts input on the first clock edge.

Test Plan:
1. XLEN=32: in_inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=0, out_illegal=0. Then 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, out_fmt=2.
2. XLEN=64: in_inst=0x80000037 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=3. in_inst=0x3002D073 (csrrwi x0,mstatus,5) -> out_imm=5, out_fmt=5.
3. Illegal opcode: in_inst=0x0000007F -> out_imm=0, out_fmt=7, out_illegal=1. With XLEN=32, in_inst=0x0000001B (opcode 0011011) -> out_illegal=1.
4. Backpressure: stream 8 tagged instructions (tags 0..7), out_ready randomly low about 50% of cycles -> all 8 delivered in order with correct tags. Check: no loss, no duplication, out_* stable while stalled, in_ready drops only while skid is full.
5. Flush with output and skid both full: assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1; the next accepted instruction emerges with its own tag.
6. Assert rst asynchronously mid-stream, between edges -> outputs take their reset values immediately without a clock. After release, the first input appears after 1 cycle.
